// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port dmem arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;

  localparam int PORT_CPU    = 0;
  localparam int PORT_DBG    = 1;
  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the port that did not win last time gets the grant.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and debug/DMA loader (port 1) onto a single dmem, with bounded lock bursts.
//   state | meaning
//   ARB   | round-robin between requesters
//   LOCK0 | port 0 holds the grant for back-to-back beats
//   LOCK1 | port 1 holds the grant for back-to-back beats
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_BURST       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       we0,
  input  logic                       we1,
  input  logic                       lock0,
  input  logic                       lock1,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr0,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]      wdata0,
  input  logic [DATA_WIDTH-1:0]      wdata1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       rvalid0,
  output logic                       rvalid1,
  output logic [DATA_WIDTH-1:0]      rdata0,
  output logic [DATA_WIDTH-1:0]      rdata1,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [DATA_WIDTH-1:0]      mem_dout
);

  arb_state_t             state, state_nxt;
  logic                   last_gnt, last_gnt_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [1:0]             req, lock, pick, gnt;
  logic                   keep, lp;
  logic [1:0]             rvalid_q;
  logic [DATA_WIDTH-1:0]  rdata0_q, rdata1_q;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt),
    .gnt  (pick)
  );

  always_comb begin
    gnt           = 2'b00;
    state_nxt     = ARB;
    last_gnt_nxt  = last_gnt;
    burst_cnt_nxt = burst_cnt;
    keep          = 1'b0;
    lp            = 1'b0;
    case (state)
      LOCK0: begin
        lp   = 1'b0;
        keep = req[0] && (!req[1] || burst_cnt < BURST_CNT_W'(MAX_BURST));
      end
      LOCK1: begin
        lp   = 1'b1;
        keep = req[1] && (!req[0] || burst_cnt < BURST_CNT_W'(MAX_BURST));
      end
      default: keep = 1'b0;
    endcase

    if (keep) begin
      gnt[lp] = 1'b1;
      if (burst_cnt != '1) burst_cnt_nxt = burst_cnt + 1'b1;
      state_nxt = lock[lp] ? state : ARB;
    end else begin
      // Lock release or expiry falls straight into round-robin with no idle cycle.
      gnt = pick;
      if (pick[0]) begin
        last_gnt_nxt = 1'b0;
        if (lock[0]) begin
          state_nxt     = LOCK0;
          burst_cnt_nxt = BURST_CNT_W'(1);
        end
      end else if (pick[1]) begin
        last_gnt_nxt = 1'b1;
        if (lock[1]) begin
          state_nxt     = LOCK1;
          burst_cnt_nxt = BURST_CNT_W'(1);
        end
      end
    end

    if (reset) gnt = 2'b00;
  end

  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt[PORT_CPU]) begin
      mem_addr  = addr0;
      mem_din   = wdata0;
      mem_read  = ~we0;
      mem_write = we0;
    end else if (gnt[PORT_DBG]) begin
      mem_addr  = addr1;
      mem_din   = wdata1;
      mem_read  = ~we1;
      mem_write = we1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      rvalid_q  <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      burst_cnt <= burst_cnt_nxt;
      rvalid_q  <= gnt & ~{we1, we0};
      if (gnt[PORT_CPU] && !we0) rdata0_q <= mem_dout;
      if (gnt[PORT_DBG] && !we1) rdata1_q <= mem_dout;
    end
  end

  // Masking with reset drops a response that was already registered when reset arrived.
  assign gnt0    = gnt[PORT_CPU];
  assign gnt1    = gnt[PORT_DBG];
  assign rvalid0 = rvalid_q[PORT_CPU] & ~reset;
  assign rvalid1 = rvalid_q[PORT_DBG] & ~reset;
  assign rdata0  = reset ? '0 : rdata0_q;
  assign rdata1  = reset ? '0 : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against an abstract arbitration/memory model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
  logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  dmem_arbiter #(.DMEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Environment dmem: asynchronous read, write commits at the clock edge.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  assign mem_dout = dmem[mem_addr];
  always @(posedge clk) if (mem_write) dmem[mem_addr] = mem_din;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return {32'hA5A5_0000 | 32'(i), ~32'(i)};
  endfunction

  // Reference model: expected memory contents and arbitration bookkeeping.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_owner = -1;
  int m_run   = 0;
  int m_last  = 1;

  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t q0[$], q1[$];

  bit pend [2];
  logic [1:0] obs_gnt;
  logic       obs_rv0, obs_mr, obs_mw;
  logic [DW-1:0] obs_rd0;
  logic [AW-1:0] obs_ma;

  task automatic model_pick(output int w);
    bit r [2];
    bit l [2];
    r[0] = req0; r[1] = req1; l[0] = lock0; l[1] = lock1;
    w = -1;
    if (m_owner >= 0 && r[m_owner] && (!r[1-m_owner] || m_run < MB)) begin
      w = m_owner;
      if (m_run < 15) m_run++;
      if (!l[w]) m_owner = -1;
    end else begin
      if (r[0] && r[1]) w = 1 - m_last;
      else if (r[0])    w = 0;
      else if (r[1])    w = 1;
      m_owner = -1;
      if (w >= 0) begin
        m_last = w;
        if (l[w]) begin m_owner = w; m_run = 1; end
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1;
    q0.delete(); q1.delete();
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input bit l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d; end
  endtask

  // One cycle: sample at the falling edge, check against the model, return 1ns after the next rising edge.
  task automatic step();
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic we;
    @(negedge clk);
    obs_gnt = {gnt1, gnt0}; obs_rv0 = rvalid0; obs_rd0 = rdata0;
    obs_mr = mem_read; obs_mw = mem_write; obs_ma = mem_addr;
    if (reset) begin
      chk("gnt_in_reset", {gnt1, gnt0}, 2'b00);
      chk("mem_rw_in_reset", {mem_read, mem_write}, 2'b00);
    end else begin
      model_pick(w);
      chk("gnt", {gnt1, gnt0}, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
      if (w < 0) begin
        chk("idle_mem", {mem_read, mem_write, mem_addr, mem_din}, '0);
      end else begin
        a  = (w == 0) ? addr0 : addr1;
        d  = (w == 0) ? wdata0 : wdata1;
        we = (w == 0) ? we0 : we1;
        chk("mem_addr", mem_addr, a);
        chk("mem_din", mem_din, d);
        chk("mem_rw", {mem_read, mem_write}, we ? 2'b01 : 2'b10);
        if (we) ref_mem[a] = d;
        else if (w == 0) q0.push_back('{cyc + 1, ref_mem[a]});
        else             q1.push_back('{cyc + 1, ref_mem[a]});
        pend[w] = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    pend[0] = 0; pend[1] = 0;
    model_reset();
    step(); step();
    reset = 1'b0;
  endtask

  // Monitor: every read response must match the oldest outstanding read of that port, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_spurious", rvalid0, 1'b0);
      else begin
        e = q0.pop_front();
        chk("rvalid0_latency", cyc, e.due);
        chk("rdata0", rdata0, e.data);
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      e = q0.pop_front();
      chk("rvalid0_missing", rvalid0, 1'b1);
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_spurious", rvalid1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("rvalid1_latency", cyc, e.due);
        chk("rdata1", rdata1, e.data);
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      chk("rvalid1_missing", rvalid1, 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] t3_gnt [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
  bit         t3_req0 [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i]    = init_val(i);
      ref_mem[i] = init_val(i);
    end
    do_reset();
    chk("reset_rvalid0", obs_rv0, 1'b0);
    chk("reset_rdata0", obs_rd0, '0);

    // Write then read back on port 0
    set_port(0, 1, 1, 0, 10'd5, 64'hDEADBEEF_00000001);
    step();
    chk("t1_write_gnt0", obs_gnt, 2'b01);
    chk("t1_mem_write", obs_mw, 1'b1);
    set_port(0, 1, 0, 0, 10'd5, '0);
    step();
    chk("t1_read_gnt0", obs_gnt, 2'b01);
    set_port(0, 0, 0, 0, '0, '0);
    step();
    chk("t1_rvalid0", obs_rv0, 1'b1);
    chk("t1_rdata0", obs_rd0, 64'hDEADBEEF_00000001);

    // Contention straight out of reset
    do_reset();
    set_port(0, 1, 0, 0, 10'd3, '0);
    set_port(1, 1, 0, 0, 10'd7, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_alternate", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    step();

    // Bounded lock: port 1 bursts, port 0 joins on beat 2
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_port(1, 1, 0, (i != 8), 10'(20 + i), '0);
      set_port(0, t3_req0[i], 0, 0, 10'd3, '0);
      step();
      chk("t3_burst", obs_gnt, t3_gnt[i]);
    end
    set_port(1, 0, 0, 0, '0, '0);
    set_port(0, 0, 0, 0, '0, '0);
    step();

    // Uncontended lock for 10 beats, released on the last
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_port(1, 1, 1, (i != 9), 10'(40 + i), 64'(i) * 64'h1111);
      step();
      chk("t4_lock_beat", obs_gnt, 2'b10);
    end
    set_port(0, 1, 0, 0, 10'd40, '0);
    set_port(1, 1, 0, 0, 10'd41, '0);
    step();
    chk("t4_after_release", obs_gnt, 2'b01);
    step();
    chk("t4_rr_resumes", obs_gnt, 2'b10);
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    step();

    // Reset the cycle after a read grant
    do_reset();
    set_port(0, 1, 0, 0, 10'd5, '0);
    step();
    chk("t5_read_gnt0", obs_gnt, 2'b01);
    reset = 1'b1;
    set_port(0, 0, 0, 0, '0, '0);
    model_reset();
    step();
    chk("t5_rvalid0_dropped", obs_rv0, 1'b0);
    chk("t5_rdata0_cleared", obs_rd0, '0);
    reset = 1'b0;
    set_port(0, 1, 0, 0, 10'd9, '0);
    set_port(1, 1, 0, 0, 10'd10, '0);
    step();
    chk("t5_port0_first", obs_gnt, 2'b01);
    chk("t5_rdata0_after", obs_rd0, '0);
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    step();

    // Idle outputs
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_idle", {obs_gnt, obs_mr, obs_mw, obs_ma}, '0);
    end

    // Random traffic with occasional reset pulses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            pend[p] = 1;
            set_port(p, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                     10'($urandom_range(0, 15)), {$urandom, $urandom});
          end else begin
            set_port(p, 0, 0, 0, '0, '0);
          end
        end
      end
      step();
    end
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    step(); step();
    chk("scoreboard_drain", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters. Port 0 is the CPU load/store path; port 1 is the debug/DMA loader, which preloads and inspects dmem.
- Arbitration is round-robin, with an optional bounded lock so a requester can perform back-to-back beats.
- Sits between the requesters and the dmem instance, and drives dmem's addr, din, mem_read and mem_write.
- Read data is registered and returned one cycle after grant.

Parameters:
- DMEM_ADDR_WIDTH, 10: width of the 64-bit word index into dmem.
- DATA_WIDTH, 64: width of the data bus.
- MAX_BURST, 4: maximum consecutive locked beats granted to one port while the other port is requesting. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until gnt is seen
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  requests that the grant be kept for the next beat
- addr0 / addr1  in  DMEM_ADDR_WIDTH  word index
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid; a one-cycle pulse
- rdata0 / rdata1  out  DATA_WIDTH  registered read data
- mem_addr  out  DMEM_ADDR_WIDTH  to dmem addr
- mem_din  out  DATA_WIDTH  to dmem din
- mem_read  out  1  to dmem mem_read
- mem_write  out  1  to dmem mem_write
- mem_dout  in  DATA_WIDTH  from dmem dout; asynchronous read, valid in the same cycle as mem_read

Behaviour:
- Reset (synchronous, active-high):
  - state = ARB, last_gnt = 1 (so port 0 wins first), burst_cnt = 0.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - While reset is high, gnt0/1, mem_read and mem_write are forced to 0.
  - An rvalid pending when reset asserts is dropped.
- Grant rules:
  - At most one gnt per cycle.
  - The granted port's addr, wdata and we drive the mem_* outputs in that cycle.
  - mem_read = gnt & ~we; mem_write = gnt & we.
  - When there is no grant: mem_read = mem_write = 0 and mem_addr/mem_din = 0.
- Write: dmem commits at the clk edge that ends the grant cycle. No response pulse is generated.
- Read:
  - rdata_p is loaded from mem_dout at the end of grant cycle N.
  - rvalid_p = 1 in cycle N+1 only.
  - rdata_p holds its value until the next read granted to the same port.
- Throughput: one access per cycle, no bubbles.
- State ARB:
  - If only one port requests, it is granted.
  - If both request, the port != last_gnt is granted.
  - On grant, last_gnt := granted port.
  - If the granted port's lock = 1: go to LOCK_p, burst_cnt := 1.
- State LOCK_p:
  - If req_p = 1 and (req_other = 0 or burst_cnt < MAX_BURST): grant p and increment burst_cnt, saturating at 15. If lock_p = 0 on this beat, go to ARB.
  - If req_p = 1, req_other = 1 and burst_cnt >= MAX_BURST: grant other and set last_gnt := other. Go to LOCK_other with burst_cnt := 1 if lock_other, else go to ARB.
  - If req_p = 0: go to ARB, and apply the ARB grant rule in the same cycle (no idle cycle).
- Simultaneous read-response and new grant to the same port: legal. The rvalid for beat N and the gnt for beat N+1 coexist in the same cycle.
- An unknown or illegal state encoding recovers to ARB.

Decomposition:
- Package dmem_arb_pkg contains:
  - typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t
  - localparam PORT_CPU = 0, PORT_DBG = 1
  - localparam BURST_CNT_W = 4
- Sub-module rr_pick2: combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs a one-hot gnt. Used in ARB and at lock release.
- The top level holds the FSM, burst counter, read-data registers and output muxing.

Test Plan:
- Write, then read:
  - Port 0 writes addr = 5, wdata = 0xDEADBEEF_00000001 with no contention → gnt0 = 1 in the same cycle and mem_write = 1.
  - Port 0 then reads addr = 5 → rvalid0 = 1 exactly one cycle after gnt0, with rdata0 = 0xDEADBEEF_00000001.
- Contention after reset:
  - Both ports read addr = 3 and addr = 7, held high → grants in order port 0, 1, 0, 1.
  - rvalid alternates one cycle behind the grants, with correct data for each address.
- Bounded lock:
  - Port 1 holds req1 and lock1 for 8 beats; port 0 requests from beat 2. With MAX_BURST = 4 → port 1 is granted beats 1–4, port 0 beat 5, then port 1 resumes.
- Lock with no contention:
  - Port 1 locks for 10 beats while req0 = 0 → all 10 beats are granted to port 1 with no gaps.
  - Deasserting lock1 on beat 10 returns the FSM to ARB.
- Reset mid-read:
  - Assert reset in the cycle immediately after a port 0 read grant → rvalid0 stays 0 and rdata0 = 0.
  - After reset releases, port 0 wins the first contended cycle.
- Idle outputs:
  - No requests for 5 cycles → mem_read = mem_write = 0, mem_addr = 0 and gnt0 = gnt1 = 0 throughout.
